imem_arbiter: RTL and testbench

- Shares the single-port instruction memory between two requesters:
  - the core instruction-fetch port;
  - the JTAG debug memory port, for program load and readback.
- Sits between the core/debug module and the instruction ROM/RAM in the SoC top.
- Sequences halt entry and exit so debug accesses never interleave with in-flight fetches.
- Prevents debug starvation while the core is running.

---
 rtl/imem_arbiter_pkg.sv | 30 +++
 rtl/imem_arb_fsm.sv | 71 +++++++
 rtl/imem_arbiter.sv | 100 ++++++++++
 tb/tb_imem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared encodings for the instruction-memory arbiter: mode FSM states and
// the owner tag of the single outstanding memory response.
package imem_arbiter_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_DRAIN = 2'd1,
      MODE_DEBUG = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_IF     = 2'd1,
      OWN_DBG_RD = 2'd2,
      OWN_DBG_WR = 2'd3
   } owner_e;

   // Owner of the response produced by this cycle's grant (at most one grant).
   function automatic owner_e grant_owner(input logic if_gnt, input logic dbg_gnt,
                                          input logic dbg_we);
      owner_e own;
      own = OWN_NONE;
      if (dbg_gnt)
         own = dbg_we ? OWN_DBG_WR : OWN_DBG_RD;
      else if (if_gnt)
         own = OWN_IF;
      return own;
   endfunction

endpackage

// File: rtl/imem_arb_fsm.sv
// Mode FSM (RUN / DRAIN / DEBUG) and debug anti-starvation wait counter.
// Tells the parent which side may be granted and when debug must be forced.
module imem_arb_fsm
   import imem_arbiter_pkg::*;
#(
   parameter int DBG_MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic halt,
   input  logic dbg_req,
   input  logic dbg_gnt,
   input  logic rsp_idle,
   output logic allow_if,
   output logic allow_dbg,
   output logic force_dbg,
   output logic dbg_mode
);

   localparam int WCW = $clog2(DBG_MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(DBG_MAX_WAIT);

   mode_e          mode_q, mode_d;
   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

   // State and counter registers; reset returns to RUN with no pending wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= MODE_RUN;
         wait_cnt_q <= '0;
      end else begin
         mode_q     <= mode_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next mode: halt drains in-flight responses before debug takes the memory.
   always_comb begin
      mode_d = mode_q;
      unique case (mode_q)
         MODE_RUN: begin
            if (halt) mode_d = MODE_DRAIN;
         end
         MODE_DRAIN: begin
            if (!halt)         mode_d = MODE_RUN;
            else if (rsp_idle) mode_d = MODE_DEBUG;
         end
         MODE_DEBUG: begin
            if (!halt) mode_d = MODE_RUN;
         end
         default: mode_d = MODE_RUN;
      endcase
   end

   // Count consecutive denied RUN cycles of a pending debug request, saturating.
   always_comb begin
      wait_cnt_d = '0;
      if ((mode_q == MODE_RUN) && !halt && dbg_req && !dbg_gnt) begin
         if (wait_cnt_q == WAIT_MAX)
            wait_cnt_d = WAIT_MAX;
         else
            wait_cnt_d = wait_cnt_q + WCW'(1);
      end
   end

   assign allow_if  = (mode_q == MODE_RUN);
   assign allow_dbg = (mode_q == MODE_RUN) || (mode_q == MODE_DEBUG);
   assign force_dbg = (mode_q == MODE_RUN) && (wait_cnt_q == WAIT_MAX);
   assign dbg_mode  = (mode_q == MODE_DEBUG);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between core fetch and JTAG debug.
// Grant mux and outstanding-response tracking; mode sequencing lives in
// imem_arb_fsm.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int DBG_MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          halt,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          dbg_mode,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   owner_e rsp_own_q, rsp_own_d;
   logic   allow_if, allow_dbg, force_dbg, fsm_dbg_mode;
   logic   if_gnt_w, dbg_gnt_w;

   imem_arb_fsm #(
      .DBG_MAX_WAIT(DBG_MAX_WAIT)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .dbg_req   (dbg_req),
      .dbg_gnt   (dbg_gnt_w),
      .rsp_idle  (rsp_own_q == OWN_NONE),
      .allow_if  (allow_if),
      .allow_dbg (allow_dbg),
      .force_dbg (force_dbg),
      .dbg_mode  (fsm_dbg_mode)
   );

   // Grant selection: fetch wins in RUN unless debug has waited too long;
   // nothing is granted while reset is held.
   always_comb begin
      dbg_gnt_w = 1'b0;
      if_gnt_w  = 1'b0;
      if (!rst) begin
         dbg_gnt_w = dbg_req && allow_dbg && (!(if_req && allow_if) || force_dbg);
         if_gnt_w  = if_req && allow_if && !dbg_gnt_w;
      end
   end

   // Memory strobe and payload from the winner; all zero when idle.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (dbg_gnt_w) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end else if (if_gnt_w) begin
         mem_en    = 1'b1;
         mem_addr  = if_addr;
      end
   end

   // Tag of the response that returns next cycle.
   always_comb begin
      rsp_own_d = grant_owner(if_gnt_w, dbg_gnt_w, dbg_we);
   end

   // Outstanding-response register; reset discards any in-flight response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rsp_own_q <= OWN_NONE;
      else     rsp_own_q <= rsp_own_d;
   end

   assign if_gnt     = if_gnt_w;
   assign dbg_gnt    = dbg_gnt_w;
   assign if_rvalid  = (rsp_own_q == OWN_IF);
   assign if_rdata   = (rsp_own_q == OWN_IF) ? mem_rdata : '0;
   assign dbg_rvalid = (rsp_own_q == OWN_DBG_RD) || (rsp_own_q == OWN_DBG_WR);
   assign dbg_rdata  = (rsp_own_q == OWN_DBG_RD) ? mem_rdata : '0;
   assign dbg_mode   = fsm_dbg_mode && !rst;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_imem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXW = 4;

   logic          clk = 1'b0;
   logic          rst, halt, if_req, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, dbg_addr;
   logic [DW-1:0] dbg_wdata;
   logic          if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, dbg_mode;
   logic [DW-1:0] if_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   imem_arbiter #(.AW(AW), .DW(DW), .DBG_MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst), .halt(halt),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .dbg_mode(dbg_mode),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Power-on memory content for word index i.
   function automatic logic [DW-1:0] pat(input logic [7:0] i);
      return {16'hC0DE, i, ~i};
   endfunction

   // Memory: 256 words; stored XOR pattern so the zero-initial array reads as pat().
   bit [DW-1:0] ram [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr[9:2]] <= mem_wdata ^ pat(mem_addr[9:2]);
         else        mem_rdata <= ram[mem_addr[9:2]] ^ pat(mem_addr[9:2]);
      end
   end

   // Reference model state.
   typedef enum {M_RUNNING, M_DRAINING, M_HALTED} mmode_t;
   mmode_t        m_mode;
   int            m_denied;
   int            m_pend;       // 0 none, 1 fetch, 2 debug read, 3 debug write
   logic [DW-1:0] m_pend_data;
   logic [DW-1:0] ref_mem [256];

   logic          o_if_gnt, o_dbg_gnt, o_mem_en, o_dbg_mode;
   logic [AW-1:0] o_mem_addr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: check all outputs against the model, then advance the model.
   task automatic step();
      logic          e_if, e_dbg, ewe, rd_pend;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      mmode_t        nm;
      #1;
      e_if  = 1'b0;
      e_dbg = 1'b0;
      if (!rst) begin
         case (m_mode)
            M_RUNNING: begin
               e_dbg = dbg_req && (!if_req || m_denied == MAXW);
               e_if  = if_req && !e_dbg;
            end
            M_HALTED: e_dbg = dbg_req;
            default: ;
         endcase
      end
      ea  = e_dbg ? dbg_addr : (e_if ? if_addr : '0);
      ewe = e_dbg && dbg_we;
      ewd = e_dbg ? dbg_wdata : '0;
      rd_pend = !rst && m_pend == 2;
      chk("if_gnt",     64'(if_gnt),     64'(e_if));
      chk("dbg_gnt",    64'(dbg_gnt),    64'(e_dbg));
      chk("mem_en",     64'(mem_en),     64'(e_if || e_dbg));
      chk("mem_we",     64'(mem_we),     64'(ewe));
      chk("mem_addr",   64'(mem_addr),   64'(ea));
      chk("mem_wdata",  64'(mem_wdata),  64'(ewd));
      chk("if_rvalid",  64'(if_rvalid),  64'(!rst && m_pend == 1));
      chk("if_rdata",   64'(if_rdata),   64'((!rst && m_pend == 1) ? m_pend_data : '0));
      chk("dbg_rvalid", 64'(dbg_rvalid), 64'(!rst && m_pend >= 2));
      chk("dbg_rdata",  64'(dbg_rdata),  64'(rd_pend ? m_pend_data : '0));
      chk("dbg_mode",   64'(dbg_mode),   64'(!rst && m_mode == M_HALTED));
      o_if_gnt   = if_gnt;
      o_dbg_gnt  = dbg_gnt;
      o_mem_en   = mem_en;
      o_mem_addr = mem_addr;
      o_dbg_mode = dbg_mode;
      @(posedge clk);
      if (rst) begin
         m_mode   = M_RUNNING;
         m_denied = 0;
         m_pend   = 0;
      end else begin
         nm = m_mode;
         case (m_mode)
            M_RUNNING:  if (halt) nm = M_DRAINING;
            M_DRAINING: if (!halt) nm = M_RUNNING; else if (m_pend == 0) nm = M_HALTED;
            default:    if (!halt) nm = M_RUNNING;
         endcase
         if (m_mode == M_RUNNING && !halt && dbg_req && !e_dbg)
            m_denied = (m_denied + 1 > MAXW) ? MAXW : m_denied + 1;
         else
            m_denied = 0;
         m_pend = e_dbg ? (dbg_we ? 3 : 2) : (e_if ? 1 : 0);
         if (e_dbg || e_if) begin
            if (ewe) ref_mem[ea[9:2]] = dbg_wdata;
            else     m_pend_data = ref_mem[ea[9:2]];
         end
         m_mode = nm;
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
      m_mode = M_RUNNING; m_denied = 0; m_pend = 0; m_pend_data = '0;
      rst = 1'b1; halt = 1'b1; if_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
      if_addr = 32'h0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
      @(negedge clk);

      // Reset with every request asserted: all outputs stay zero.
      step();
      step();
      rst = 1'b0; halt = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
      step();

      // Back-to-back fetches.
      if_req = 1'b1; if_addr = 32'h100;
      step(); chk("fetch_gnt_100", 64'(o_if_gnt), 64'd1);
      chk("fetch_data_100", 64'(if_rdata), 64'(pat(8'h40)));
      if_addr = 32'h104;
      step(); chk("fetch_data_104", 64'(if_rdata), 64'(pat(8'h41)));
      if_addr = 32'h108;
      step(); chk("fetch_data_108", 64'(if_rdata), 64'(pat(8'h42)));
      chk("fetch_no_dbg_rvalid", 64'(dbg_rvalid), 64'd0);
      if_req = 1'b0;
      step();

      // Starvation: fetch held, debug read forced on the 5th cycle.
      if_req = 1'b1; if_addr = 32'h200;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wdata = 32'hDEADBEEF;
      for (int k = 0; k < MAXW; k++) begin
         step(); chk("starve_deny", 64'(o_dbg_gnt), 64'd0);
      end
      step();
      chk("starve_force_dbg", 64'(o_dbg_gnt), 64'd1);
      chk("starve_no_if", 64'(o_if_gnt), 64'd0);
      chk("starve_mem_addr", 64'(o_mem_addr), 64'h20);
      dbg_req = 1'b0;
      chk("starve_rdata", 64'(dbg_rdata), 64'(pat(8'h08)));
      step(); chk("starve_fetch_resume", 64'(o_if_gnt), 64'd1);

      // Halt rising with a fetch grant: response completes in DRAIN.
      if_addr = 32'h40; halt = 1'b1;
      step(); chk("halt_fetch_gnt", 64'(o_if_gnt), 64'd1);
      chk("halt_fetch_data", 64'(if_rdata), 64'(pat(8'h10)));
      if_addr = 32'h44;
      step(); chk("drain_no_gnt", 64'(o_mem_en), 64'd0);
      step(); chk("debug_mode_on", 64'(dbg_mode), 64'd1);
      step(); chk("debug_if_ignored", 64'(o_if_gnt), 64'd0);
      if_req = 1'b0;

      // Debug program load and readback.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h11111111;
      step(); chk("dbg_wr0_gnt", 64'(o_dbg_gnt), 64'd1);
      dbg_addr = 32'h4; dbg_wdata = 32'h22222222;
      step(); chk("dbg_wr_rvalid", 64'(dbg_rvalid), 64'd1);
      dbg_we = 1'b0; dbg_addr = 32'h0;
      step(); chk("dbg_rd0", 64'(dbg_rdata), 64'h11111111);
      dbg_addr = 32'h4;
      step(); chk("dbg_rd4", 64'(dbg_rdata), 64'h22222222);
      dbg_req = 1'b0; halt = 1'b0; if_req = 1'b1; if_addr = 32'h0;
      step(); chk("exit_debug_no_fetch", 64'(o_if_gnt), 64'd0);
      step(); chk("run_fetch_gnt", 64'(o_if_gnt), 64'd1);
      chk("run_fetch_loaded", 64'(if_rdata), 64'h11111111);
      if_req = 1'b0;

      // Reset the cycle after a debug read grant.
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
      step(); chk("rstrd_gnt", 64'(o_dbg_gnt), 64'd1);
      dbg_req = 1'b0; rst = 1'b1; halt = 1'b1;
      step();
      rst = 1'b0;
      chk("rstrd_no_rvalid", 64'(dbg_rvalid), 64'd0);
      step(); chk("rstrd_run_mode", 64'(o_dbg_mode), 64'd0);
      if_req = 1'b1; if_addr = 32'h10;
      step(); chk("rstrd_drain_nogrant", 64'(o_if_gnt), 64'd0);
      halt = 1'b0;
      step();
      step();

      // Random traffic; requesters hold payload until granted.
      if_req = 1'b0; dbg_req = 1'b0;
      o_if_gnt = 1'b0; o_dbg_gnt = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!if_req || o_if_gnt) begin
            if_req  = ($urandom_range(0, 9) < 7);
            if_addr = {22'b0, 8'($urandom), 2'b00};
         end
         if (!dbg_req || o_dbg_gnt) begin
            dbg_req   = ($urandom_range(0, 9) < 4);
            dbg_we    = 1'($urandom);
            dbg_addr  = {22'b0, 8'($urandom), 2'b00};
            dbg_wdata = $urandom;
         end
         if ($urandom_range(0, 24) == 0) halt = ~halt;
         rst = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
